// File: rtl/spi_adapter_host.sv
// SPI host adapter: turns latency-insensitive request/response messages into
// SPI frames of {val_wrt, val_rd, payload} and decodes {spc, val, payload}
// returned by the minion. Holds one request and one response register.
module spi_adapter_host #(
  parameter int BIT_WIDTH = 36,  // 4-bit router address + 32-bit data
  parameter int CLK_DIV   = 2    // clk cycles per sclk half-period (1..255)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  input  logic [BIT_WIDTH-1:0] recv_msg,
  output logic                 send_val,
  input  logic                 send_rdy,
  output logic [BIT_WIDTH-1:0] send_msg,
  input  logic                 poll_en,
  output logic                 spi_cs,
  output logic                 spi_sclk,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);

  localparam int FW = BIT_WIDTH + 2;
  localparam int CW = $clog2(BIT_WIDTH + 3);
  localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(FW - 1);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, DONE} state_t;

  state_t               state_q, state_d;
  logic [7:0]           div_q, div_d;
  logic [CW-1:0]        bit_q, bit_d;
  logic [FW-1:0]        tx_q, tx_d;
  logic [FW-1:0]        rx_q, rx_d;
  logic                 req_full_q, req_full_d;
  logic                 resp_full_q, resp_full_d;
  logic [BIT_WIDTH-1:0] req_q, req_d;
  logic [BIT_WIDTH-1:0] resp_q, resp_d;
  logic                 val_wrt_q, val_wrt_d;
  logic                 val_rd_q, val_rd_d;
  logic                 div_end;
  logic [BIT_WIDTH-1:0] tx_payload;

  // Next-state logic: message buffers plus the frame sequencer.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    req_full_d  = req_full_q;
    resp_full_d = resp_full_q;
    req_d       = req_q;
    resp_d      = resp_q;
    val_wrt_d   = val_wrt_q;
    val_rd_d    = val_rd_q;
    div_end     = (div_q == DIV_LAST);
    tx_payload  = req_full_q ? req_q : {BIT_WIDTH{1'b0}};

    // Enqueue only into an empty request slot, so a frame in flight never
    // sees its request change underneath it.
    if (recv_val && !req_full_q) begin
      req_d      = recv_msg;
      req_full_d = 1'b1;
    end
    if (send_rdy && resp_full_q) begin
      resp_full_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // Frame flags come from the registered buffer state, before any
        // enqueue/dequeue happening in this same cycle.
        if (req_full_q || (poll_en && !resp_full_q)) begin
          state_d   = SETUP;
          div_d     = 8'd0;
          bit_d     = '0;
          val_wrt_d = req_full_q;
          val_rd_d  = !resp_full_q;
          tx_d      = {req_full_q, !resp_full_q, tx_payload};
          rx_d      = '0;
        end
      end
      SETUP, LOW: begin
        if (div_end) begin
          div_d   = 8'd0;
          state_d = (state_q == SETUP) ? LOW : HIGH;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      HIGH: begin
        if (div_q == 8'd0) begin
          rx_d = {rx_q[FW-2:0], spi_miso};
        end
        if (div_end) begin
          div_d = 8'd0;
          tx_d  = {tx_q[FW-2:0], 1'b0};
          if (bit_q == BIT_LAST) begin
            state_d = HOLD;
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = LOW;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      HOLD: begin
        if (div_end) begin
          div_d   = 8'd0;
          state_d = DONE;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      DONE: begin
        // rx_q = {spc, val, payload}; spc=0 leaves the request for a retry.
        state_d = IDLE;
        bit_d   = '0;
        if (val_wrt_q && rx_q[FW-1]) begin
          req_full_d = 1'b0;
        end
        if (val_rd_q && rx_q[FW-2]) begin
          resp_d      = rx_q[BIT_WIDTH-1:0];
          resp_full_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; reset also aborts any frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      div_q       <= 8'd0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      req_full_q  <= 1'b0;
      resp_full_q <= 1'b0;
      req_q       <= '0;
      resp_q      <= '0;
      val_wrt_q   <= 1'b0;
      val_rd_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      req_full_q  <= req_full_d;
      resp_full_q <= resp_full_d;
      req_q       <= req_d;
      resp_q      <= resp_d;
      val_wrt_q   <= val_wrt_d;
      val_rd_q    <= val_rd_d;
    end
  end

  // Outputs decoded from registered state only (glitch-free SPI pins).
  always_comb begin
    recv_rdy = !req_full_q;
    send_val = resp_full_q;
    send_msg = resp_q;
    spi_cs   = !(state_q inside {SETUP, LOW, HIGH, HOLD});
    spi_sclk = (state_q == HIGH);
    spi_mosi = (state_q inside {SETUP, LOW, HIGH}) ? tx_q[FW-1] : 1'b0;
  end

endmodule

// File: tb/tb_spi_adapter_host.sv
// Scoreboard bench: stimulus pushes expected mosi frames and responses into
// queues; monitors compare them as frames complete and responses handshake.
module tb_spi_adapter_host;

  localparam int W  = 36;
  localparam int FW = 38;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, reset_b;
  logic          recv_val, recv_rdy;
  logic [W-1:0]  recv_msg;
  logic          send_val, send_rdy;
  logic [W-1:0]  send_msg;
  logic          poll_en;
  logic          spi_cs, spi_sclk, spi_mosi;
  logic          spi_miso = 1'b0;

  logic          b_recv_rdy, b_send_val, b_cs, b_sclk, b_mosi;
  logic [W-1:0]  b_send_msg;

  int total = 0;
  int bad   = 0;
  int frames_a = 0;
  int frames_b = 0;

  logic [FW-1:0] exp_frame_q[$];
  logic [FW-1:0] minion_q[$];
  logic [W-1:0]  exp_resp_q[$];

  spi_adapter_host #(.BIT_WIDTH(36), .CLK_DIV(2)) dut (
    .clk(clk), .reset(reset),
    .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg),
    .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg),
    .poll_en(poll_en),
    .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  spi_adapter_host #(.BIT_WIDTH(36), .CLK_DIV(1)) dut_fast (
    .clk(clk), .reset(reset_b),
    .recv_val(1'b0), .recv_rdy(b_recv_rdy), .recv_msg(36'h0),
    .send_val(b_send_val), .send_rdy(1'b1), .send_msg(b_send_msg),
    .poll_en(1'b1),
    .spi_cs(b_cs), .spi_sclk(b_sclk), .spi_mosi(b_mosi), .spi_miso(1'b0)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Minion model + frame monitor for the CLK_DIV=2 instance.
  logic [FW-1:0] a_cap, a_mresp;
  int            a_low, a_bits;
  logic          a_in = 1'b0, a_prev_cs = 1'b1, a_prev_sclk = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      a_in = 1'b0; a_prev_cs = 1'b1; a_prev_sclk = 1'b0; spi_miso = 1'b0;
    end else begin
      if (a_prev_cs && !spi_cs) begin
        a_in = 1'b1; a_cap = '0; a_bits = 0; a_low = 0;
        a_mresp = (minion_q.size() > 0) ? minion_q.pop_front() : '0;
        spi_miso = a_mresp[FW-1];
      end
      if (!spi_cs) a_low++;
      if (!a_prev_sclk && spi_sclk) begin
        a_cap = {a_cap[FW-2:0], spi_mosi};
        a_bits++;
      end
      if (a_prev_sclk && !spi_sclk) begin
        a_mresp = {a_mresp[FW-2:0], 1'b0};
        spi_miso = a_mresp[FW-1];
      end
      if (!a_prev_cs && spi_cs && a_in) begin
        a_in = 1'b0;
        $display("frame %0d: mosi=%h bits=%0d cs_low=%0d", frames_a, a_cap, a_bits, a_low);
        if (exp_frame_q.size() == 0) begin
          chk("unexpected_frame", {26'h0, a_cap}, 64'h0);
        end else begin
          chk("frame_mosi", {26'h0, a_cap}, {26'h0, exp_frame_q.pop_front()});
        end
        chk("frame_bits", a_bits, 38);
        chk("frame_cs_low", a_low, 156);
        frames_a++;
      end
      a_prev_cs = spi_cs;
      a_prev_sclk = spi_sclk;
    end
  end

  // Response scoreboard: compare whenever a response handshake is about to occur.
  always @(negedge clk) begin
    if (!reset && send_val && send_rdy) begin
      $display("response: send_msg=%h", send_msg);
      if (exp_resp_q.size() == 0) chk("unexpected_resp", send_msg, 64'h0);
      else chk("resp_msg", send_msg, exp_resp_q.pop_front());
    end
  end

  // Monitor for the CLK_DIV=1 polling instance with a silent minion.
  logic [FW-1:0] b_cap;
  int            b_low, b_bits, b_period = 0;
  logic          b_in = 1'b0, b_seen = 1'b0, b_prev_cs = 1'b1, b_prev_sclk = 1'b0;
  always @(negedge clk) begin
    if (reset_b) begin
      b_in = 1'b0; b_seen = 1'b0; b_prev_cs = 1'b1; b_prev_sclk = 1'b0;
    end else begin
      b_period++;
      if (b_prev_cs && !b_cs) begin
        if (b_seen && frames_b < 10) chk("fast_period", b_period, 80);
        b_seen = 1'b1; b_period = 0; b_in = 1'b1; b_cap = '0; b_bits = 0; b_low = 0;
      end
      if (!b_cs) b_low++;
      if (!b_prev_sclk && b_sclk) begin
        b_cap = {b_cap[FW-2:0], b_mosi};
        b_bits++;
      end
      if (!b_prev_cs && b_cs && b_in) begin
        b_in = 1'b0;
        if (frames_b < 10) begin
          $display("fast frame %0d: mosi=%h cs_low=%0d", frames_b, b_cap, b_low);
          chk("fast_mosi", {26'h0, b_cap}, {26'h0, 2'b01, 36'h0});
          chk("fast_bits", b_bits, 38);
          chk("fast_cs_low", b_low, 78);
          chk("fast_no_resp", {b_send_val, b_send_msg}, 64'h0);
          chk("fast_recv_rdy", b_recv_rdy, 1);
        end
        frames_b++;
      end
      b_prev_cs = b_cs;
      b_prev_sclk = b_sclk;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enqueue(input logic [W-1:0] msg);
    int n = 0;
    step();
    while (!recv_rdy && n < 3000) begin step(); n++; end
    $display("enqueue: recv_msg=%h", msg);
    recv_val = 1'b1;
    recv_msg = msg;
    step();
    recv_val = 1'b0;
    recv_msg = ~msg;  // must not leak into the frame
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames_a < target && n < 3000) begin @(negedge clk); n++; end
    chk("frame_timeout", frames_a >= target, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_cs_low();
    int n = 0;
    while (spi_cs && n < 3000) begin @(negedge clk); n++; end
    chk("cs_low_timeout", spi_cs, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; reset_b = 1'b1;
    recv_val = 1'b0; recv_msg = '0; send_rdy = 1'b1; poll_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", spi_cs, 1);
    chk("rst_sclk", spi_sclk, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_recv_rdy", recv_rdy, 1);
    chk("rst_send_val", send_val, 0);
    step();
    reset = 1'b0; reset_b = 1'b0;

    // Write accepted, no response.
    minion_q.push_back({2'b10, 36'h0});
    exp_frame_q.push_back({2'b11, 36'h1_DEADBEEF});
    enqueue(36'h1_DEADBEEF);
    wait_cs_low();
    repeat (50) @(negedge clk);
    chk("t1_rdy_low", recv_rdy, 0);
    wait_frames(1);
    chk("t1_rdy_high", recv_rdy, 1);
    chk("t1_no_resp", send_val, 0);

    // Loopback: write, then a poll frame returns the data.
    send_rdy = 1'b0;
    minion_q.push_back({2'b10, 36'h0});
    exp_frame_q.push_back({2'b11, 36'h0_12345678});
    enqueue(36'h0_12345678);
    wait_frames(2);
    minion_q.push_back({2'b11, 36'h0_12345678});
    exp_frame_q.push_back({2'b01, 36'h0});
    exp_resp_q.push_back(36'h0_12345678);
    poll_en = 1'b1;
    wait_frames(3);
    repeat (20) @(negedge clk);
    chk("t2_send_val_held", send_val, 1);
    chk("t2_send_msg", send_msg, 36'h0_12345678);
    chk("t2_no_extra_frame", frames_a, 3);
    step();
    poll_en = 1'b0;
    send_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("t2_resp_drained", exp_resp_q.size(), 0);
    chk("t2_send_val_clr", send_val, 0);

    // Backpressure: spc=0 twice, then spc=1.
    minion_q.push_back({2'b00, 36'h0});
    minion_q.push_back({2'b00, 36'h0});
    minion_q.push_back({2'b10, 36'h0});
    for (int i = 0; i < 3; i++) exp_frame_q.push_back({2'b11, 36'h5_A5A5A5A5});
    enqueue(36'h5_A5A5A5A5);
    wait_frames(4);
    chk("t3_retry1_full", recv_rdy, 0);
    wait_frames(5);
    chk("t3_retry2_full", recv_rdy, 0);
    wait_frames(6);
    chk("t3_cleared", recv_rdy, 1);
    repeat (400) @(negedge clk);
    chk("t3_exactly3", frames_a, 6);

    // Response buffer full: polling stops, write frame carries val_rd=0.
    step();
    send_rdy = 1'b0;
    minion_q.push_back({2'b11, 36'h9_00000001});
    exp_frame_q.push_back({2'b01, 36'h0});
    exp_resp_q.push_back(36'h9_00000001);
    poll_en = 1'b1;
    wait_frames(7);
    repeat (400) @(negedge clk);
    chk("t4_no_poll_when_full", frames_a, 7);
    minion_q.push_back({2'b11, 36'hF_FFFFFFFF});
    exp_frame_q.push_back({2'b10, 36'h3_00C0FFEE});
    enqueue(36'h3_00C0FFEE);
    wait_frames(8);
    chk("t4_resp_kept", send_msg, 36'h9_00000001);
    chk("t4_req_cleared", recv_rdy, 1);
    step();
    poll_en = 1'b0;
    send_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("t4_resp_drained", exp_resp_q.size(), 0);

    // Reset in the middle of a frame.
    minion_q.push_back({2'b10, 36'h0});
    enqueue(36'h7_77777777);
    wait_cs_low();
    repeat (40) @(negedge clk);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("t5_mid_frame", spi_cs, 0);
    @(negedge clk);
    chk("t5_cs_high", spi_cs, 1);
    chk("t5_sclk_low", spi_sclk, 0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("t5_recv_rdy", recv_rdy, 1);
    chk("t5_send_val", send_val, 0);
    repeat (400) @(negedge clk);
    chk("t5_req_discarded", frames_a, 8);
    minion_q.push_back({2'b10, 36'h0});
    exp_frame_q.push_back({2'b11, 36'h2_468ACE13});
    enqueue(36'h2_468ACE13);
    wait_frames(9);
    chk("t5_after_reset_done", recv_rdy, 1);

    chk("fast_frames_seen", frames_b >= 10, 1);
    chk("frames_left", exp_frame_q.size(), 0);
    chk("minion_left", minion_q.size(), 0);
    chk("resp_left", exp_resp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_adapter_host.md
SPI_ADAPTER_HOST -- requirements
Module: SPIAdapterHostVRTL

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 36, meaning addressed payload width: 4-bit router address plus 32-bit data.
REQ-002 SHALL have parameter CLK_DIV, default 2, meaning clk cycles per sclk half-period; legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have ports recv_val (input, 1), recv_rdy (output, 1) and recv_msg (input, BIT_WIDTH), carrying requests to send to the minion.
REQ-006 SHALL have ports send_val (output, 1), send_rdy (input, 1) and send_msg (output, BIT_WIDTH), carrying responses returned by the minion.
REQ-007 SHALL have port poll_en, input, 1 bit, which enables read-only frames when no request is pending.
REQ-008 SHALL have ports spi_cs (output, 1, active-low), spi_sclk (output, 1), spi_mosi (output, 1) and spi_miso (input, 1).

Function
REQ-009 SHALL hold one request register: recv_rdy = !req_full; recv_val && recv_rdy loads recv_msg and sets req_full.
REQ-010 SHALL hold one response register: send_val = resp_full, send_msg = response; send_val && send_rdy clears resp_full.
REQ-011 SHALL implement the FSM IDLE -> SETUP -> LOW <-> HIGH -> HOLD -> DONE -> IDLE.
REQ-012 In IDLE, SHALL start a frame when req_full || (poll_en && !resp_full); otherwise remain in IDLE.
REQ-013 At frame start, SHALL load a (BIT_WIDTH+2)-bit shift register {val_wrt=req_full, val_rd=!resp_full, payload}; payload = request if req_full, else 0.
REQ-014 SHALL sample val_wrt and val_rd from register values before any same-cycle enqueue or dequeue.
REQ-015 SETUP, each LOW and each HIGH, and HOLD SHALL each last exactly CLK_DIV cycles; spi_cs = 0 throughout these states.
REQ-016 During LOW, sclk = 0 and mosi = shift-register MSB; during HIGH, sclk = 1 and mosi is unchanged.
REQ-017 SHALL sample spi_miso into the receive shift register, MSB first, on the first cycle of each HIGH.
REQ-018 SHALL shift the transmit register left by one at the end of each HIGH.
REQ-019 After BIT_WIDTH+2 HIGH phases, SHALL go to HOLD with sclk = 0.
REQ-020 DONE SHALL last 1 cycle with cs = 1, so a frame totals (2*(BIT_WIDTH+2)+2)*CLK_DIV + 1 cycles.
REQ-021 In DONE, SHALL decode the received frame as {spc, val, payload}.
REQ-022 In DONE, if val_wrt && spc, SHALL clear req_full; if val_wrt && !spc, SHALL keep the request and retry it unchanged in the next frame.
REQ-023 In DONE, if val_rd && val, SHALL load payload into the response register and set resp_full.
REQ-024 In DONE, if !val_rd, SHALL discard the received val and payload.
REQ-025 recv_msg and recv_val changes during a frame SHALL not alter the transmitted bits.
REQ-026 Frames SHALL be back-to-back, with IDLE lasting at least 1 cycle between them.
REQ-027 The bit counter SHALL be sized to $clog2(BIT_WIDTH+3) bits; the divider counter SHALL be 8 bits.

Reset
REQ-028 On reset, SHALL set state = IDLE, spi_cs = 1, spi_sclk = 0, spi_mosi = 0, recv_rdy = 1 (next cycle) and send_val = 0.
REQ-029 On reset, SHALL clear req_full, resp_full, all counters and both shift registers.
REQ-030 Reset mid-frame SHALL abort the frame immediately, with cs high the following cycle, and discard the held request and any partial response.

Verification (BIT_WIDTH=36, CLK_DIV=2, frame = 157 cycles)
REQ-031 Write accepted: recv_msg=0x1_DEADBEEF, minion returns spc=1, val=0 -> mosi bits = 1,1 followed by 0x1DEADBEEF MSB first; recv_rdy stays low for the frame and returns high after DONE; no response.
REQ-032 Loopback: request 0x0_12345678, minion returns spc=1, val=1 with payload 0x0_12345678 in the next poll frame -> send_val=1, send_msg=0x012345678, held until send_rdy.
REQ-033 Backpressure retry: minion returns spc=0 twice, then spc=1 -> exactly 3 identical frames, and req_full clears only after the third.
REQ-034 Response buffer full: send_rdy=0, poll_en=1, resp_full=1 -> no frames issued; with a request pending, the frame carries val_rd=0 and a returned val=1 is ignored.
REQ-035 Reset asserted in the middle of a frame -> cs=1 and sclk=0 the next cycle; recv_rdy=1 and send_val=0 after reset deasserts; the next frame starts from bit 0.
REQ-036 CLK_DIV=1 with poll_en=1 and an idle minion -> continuous 79-cycle read-only frames, with mosi prefix 0,1 and a zero payload.
